// File: rtl/timer_counter.sv
// Prescaled COUNTER_SIZE-bit time base (up / down / up-down / one-shot) with sticky compare flags.
// Define TIMER_SHADOW_EN to double-buffer period and match_value.
module timer_counter #(
    parameter int COUNTER_SIZE = 32,
    parameter int NUM_COMP     = 2,
    parameter int PRESC_SIZE   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [PRESC_SIZE-1:0]            presc_value,
    input  logic [COUNTER_SIZE-1:0]          period,
    input  logic [1:0]                       mode,
    input  logic                             load,
    input  logic [COUNTER_SIZE-1:0]          load_value,
    input  logic [NUM_COMP*COUNTER_SIZE-1:0] match_value,
    input  logic [NUM_COMP-1:0]              flag_clr,
    output logic [COUNTER_SIZE-1:0]          counter_value,
    output logic                             tick,
    output logic                             overflow,
    output logic                             dir,
    output logic [NUM_COMP-1:0]              flag,
    output logic                             running
);

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_UPDOWN  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

    localparam logic [COUNTER_SIZE-1:0] CNT_ONE   = COUNTER_SIZE'(1);
    localparam logic [PRESC_SIZE-1:0]   PRESC_ONE = PRESC_SIZE'(1);

    logic [PRESC_SIZE-1:0]            presc_cnt;
    logic [PRESC_SIZE-1:0]            presc_cnt_n;
    logic                             presc_tick;
    logic                             done;
    logic                             done_n;
    logic [COUNTER_SIZE-1:0]          cnt_n;
    logic                             dir_n;
    logic                             ovf_n;
    logic                             adv;
    logic [NUM_COMP-1:0]              flag_n;
    logic                             running_n;
    logic [COUNTER_SIZE-1:0]          period_act;
    logic [COUNTER_SIZE-1:0]          period_last;
    logic [NUM_COMP*COUNTER_SIZE-1:0] match_act;

`ifdef TIMER_SHADOW_EN
    // Active copies only move at period boundaries, on load, or while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_act <= '0;
            match_act  <= '0;
        end else if (ovf_n || load || !en) begin
            period_act <= period;
            match_act  <= match_value;
        end
    end
`else
    assign period_act = period;
    assign match_act  = match_value;
`endif

    assign period_last = period_act - CNT_ONE;
    assign presc_tick  = en && (presc_cnt >= presc_value);

    always_comb begin
        presc_cnt_n = presc_cnt;
        if (load || presc_tick)
            presc_cnt_n = '0;
        else if (en)
            presc_cnt_n = presc_cnt + PRESC_ONE;
    end

    always_comb begin
        cnt_n  = counter_value;
        dir_n  = dir;
        ovf_n  = 1'b0;
        adv    = 1'b0;
        done_n = (mode == MODE_ONESHOT) ? done : 1'b0;
        case (mode)
            MODE_UP, MODE_ONESHOT: dir_n = 1'b0;
            MODE_DOWN:             dir_n = 1'b1;
            default:               dir_n = dir;
        endcase
        if (load) begin
            cnt_n  = load_value;
            done_n = 1'b0;
        end else if (presc_tick && !(mode == MODE_ONESHOT && done)) begin
            adv = 1'b1;
            if (period_act == '0) begin
                cnt_n = '0;
                ovf_n = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        if (counter_value >= period_act) begin
                            cnt_n = '0;
                            ovf_n = 1'b1;
                        end else begin
                            cnt_n = counter_value + CNT_ONE;
                        end
                    end
                    MODE_DOWN: begin
                        if (counter_value == '0) begin
                            cnt_n = period_act;
                            ovf_n = 1'b1;
                        end else begin
                            cnt_n = counter_value - CNT_ONE;
                        end
                    end
                    // Turn around on reaching either end so top and bottom each last one tick.
                    MODE_UPDOWN: begin
                        if (!dir) begin
                            if (counter_value >= period_last) begin
                                cnt_n = period_act;
                                dir_n = 1'b1;
                            end else begin
                                cnt_n = counter_value + CNT_ONE;
                            end
                        end else begin
                            if (counter_value <= CNT_ONE) begin
                                cnt_n = '0;
                                dir_n = 1'b0;
                                ovf_n = 1'b1;
                            end else begin
                                cnt_n = counter_value - CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        if (counter_value >= period_last) begin
                            cnt_n  = (counter_value > period_act) ? counter_value : period_act;
                            ovf_n  = 1'b1;
                            done_n = 1'b1;
                        end else begin
                            cnt_n = counter_value + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    // A set from this cycle's new count wins over a simultaneous clear.
    always_comb begin
        flag_n = flag & ~flag_clr;
        for (int i = 0; i < NUM_COMP; i++) begin
            if ((load || adv) && (cnt_n == match_act[i*COUNTER_SIZE +: COUNTER_SIZE]))
                flag_n[i] = 1'b1;
        end
    end

    assign running_n = en && !done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt     <= '0;
            counter_value <= '0;
            tick          <= 1'b0;
            overflow      <= 1'b0;
            dir           <= 1'b0;
            flag          <= '0;
            running       <= 1'b0;
            done          <= 1'b0;
        end else begin
            presc_cnt     <= presc_cnt_n;
            counter_value <= cnt_n;
            tick          <= adv;
            overflow      <= ovf_n;
            dir           <= dir_n;
            flag          <= flag_n;
            running       <= running_n;
            done          <= done_n;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed-vector bench for timer_counter; expectations follow the TIMER_SHADOW_EN setting of the build.
module tb_timer_counter;

    localparam int CS = 32;
    localparam int NC = 2;
    localparam int PS = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0;
    logic [PS-1:0]  presc_value = '0;
    logic [CS-1:0]  period = '0;
    logic [1:0]     mode = 2'b00;
    logic           load = 1'b0;
    logic [CS-1:0]  load_value = '0;
    logic [NC*CS-1:0] match_value = '1;
    logic [NC-1:0]  flag_clr = '0;
    logic [CS-1:0]  counter_value;
    logic           tick;
    logic           overflow;
    logic           dir;
    logic [NC-1:0]  flag;
    logic           running;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_counter #(.COUNTER_SIZE(CS), .NUM_COMP(NC), .PRESC_SIZE(PS)) dut (
        .clk(clk), .rst(rst), .en(en), .presc_value(presc_value), .period(period),
        .mode(mode), .load(load), .load_value(load_value), .match_value(match_value),
        .flag_clr(flag_clr), .counter_value(counter_value), .tick(tick),
        .overflow(overflow), .dir(dir), .flag(flag), .running(running)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prep(input logic [1:0] m, input logic [CS-1:0] per,
                        input logic [PS-1:0] pv, input logic [CS-1:0] lv);
        en = 1'b0; mode = m; period = per; presc_value = pv;
        load_value = lv; load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset();
        cyc(2);
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", counter_value); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", dir); end
        checks++; if (flag !== 2'b00) begin errors++; $display("FAIL reset_flag got %b want 00", flag); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        rst = 1'b1;
        cyc(1);
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL post_reset_count got %0d want 0", counter_value); end
    endtask

    task automatic test_up();
        int  e_cnt[6] = '{1, 2, 3, 4, 0, 1};
        bit  e_ovf[6] = '{0, 0, 0, 0, 1, 0};
        prep(2'b00, 4, 0, 0);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            checks++; if (counter_value !== e_cnt[k]) begin errors++; $display("FAIL up_count[%0d] got %0d want %0d", k, counter_value, e_cnt[k]); end
            checks++; if (overflow !== e_ovf[k]) begin errors++; $display("FAIL up_ovf[%0d] got %b want %b", k, overflow, e_ovf[k]); end
            checks++; if (tick !== 1'b1) begin errors++; $display("FAIL up_tick[%0d] got %b want 1", k, tick); end
        end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL up_running got %b want 1", running); end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_down();
        int e_cnt[12] = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
        prep(2'b01, 3, 2, 3);
        checks++; if (counter_value !== 3) begin errors++; $display("FAIL down_load got %0d want 3", counter_value); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL down_dir got %b want 1", dir); end
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            checks++; if (counter_value !== e_cnt[k-1]) begin errors++; $display("FAIL down_count[%0d] got %0d want %0d", k, counter_value, e_cnt[k-1]); end
            checks++; if (tick !== (k % 3 == 0)) begin errors++; $display("FAIL down_tick[%0d] got %b want %b", k, tick, (k % 3 == 0)); end
            checks++; if (overflow !== (k == 12)) begin errors++; $display("FAIL down_ovf[%0d] got %b want %b", k, overflow, (k == 12)); end
        end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_updown();
        int e_cnt[6] = '{1, 2, 1, 0, 1, 2};
        bit e_dir[6] = '{0, 1, 1, 0, 0, 1};
        bit e_ovf[6] = '{0, 0, 0, 1, 0, 0};
        prep(2'b00, 2, 0, 0);
        mode = 2'b10;
        cyc(1);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            checks++; if (counter_value !== e_cnt[k]) begin errors++; $display("FAIL updown_count[%0d] got %0d want %0d", k, counter_value, e_cnt[k]); end
            checks++; if (dir !== e_dir[k]) begin errors++; $display("FAIL updown_dir[%0d] got %b want %b", k, dir, e_dir[k]); end
            checks++; if (overflow !== e_ovf[k]) begin errors++; $display("FAIL updown_ovf[%0d] got %b want %b", k, overflow, e_ovf[k]); end
        end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_oneshot();
        int e_cnt[7] = '{1, 2, 3, 4, 5, 5, 5};
        bit e_ovf[7] = '{0, 0, 0, 0, 1, 0, 0};
        bit e_run[7] = '{1, 1, 1, 1, 0, 0, 0};
        bit e_tck[7] = '{1, 1, 1, 1, 1, 0, 0};
        prep(2'b11, 5, 0, 0);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL oneshot_idle_running got %b want 0", running); end
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc(1);
            checks++; if (counter_value !== e_cnt[k]) begin errors++; $display("FAIL oneshot_count[%0d] got %0d want %0d", k, counter_value, e_cnt[k]); end
            checks++; if (overflow !== e_ovf[k]) begin errors++; $display("FAIL oneshot_ovf[%0d] got %b want %b", k, overflow, e_ovf[k]); end
            checks++; if (running !== e_run[k]) begin errors++; $display("FAIL oneshot_running[%0d] got %b want %b", k, running, e_run[k]); end
            checks++; if (tick !== e_tck[k]) begin errors++; $display("FAIL oneshot_tick[%0d] got %b want %b", k, tick, e_tck[k]); end
        end
        load_value = 0; load = 1'b1;
        cyc(1);
        load = 1'b0;
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL oneshot_rearm_count got %0d want 0", counter_value); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL oneshot_rearm_tick got %b want 0", tick); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL oneshot_rearm_running got %b want 1", running); end
        cyc(1);
        checks++; if (counter_value !== 1) begin errors++; $display("FAIL oneshot_restart got %0d want 1", counter_value); end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_flag();
        match_value = {32'd6, 32'd3};
        prep(2'b00, 7, 0, 0);
        checks++; if (flag !== 2'b00) begin errors++; $display("FAIL flag_idle got %b want 00", flag); end
        en = 1'b1;
        cyc(2);
        checks++; if (flag !== 2'b00) begin errors++; $display("FAIL flag_before got %b want 00", flag); end
        cyc(1);
        checks++; if (flag !== 2'b01) begin errors++; $display("FAIL flag_set0 got %b want 01", flag); end
        cyc(3);
        checks++; if (flag !== 2'b11) begin errors++; $display("FAIL flag_set1 got %b want 11", flag); end
        flag_clr = 2'b01;
        cyc(1);
        checks++; if (flag !== 2'b10) begin errors++; $display("FAIL flag_clr0 got %b want 10", flag); end
        flag_clr = 2'b00;
        cyc(3);
        checks++; if (counter_value !== 2) begin errors++; $display("FAIL flag_wrap_count got %0d want 2", counter_value); end
        flag_clr = 2'b01;
        cyc(1);
        checks++; if (flag !== 2'b11) begin errors++; $display("FAIL flag_set_wins got %b want 11", flag); end
        flag_clr = 2'b10;
        cyc(1);
        checks++; if (flag !== 2'b01) begin errors++; $display("FAIL flag_clr1 got %b want 01", flag); end
        flag_clr = 2'b00;
        en = 1'b0;
        match_value = '1;
        cyc(1);
    endtask

    task automatic test_period_change();
`ifdef TIMER_SHADOW_EN
        int e_cnt[6] = '{6, 7, 0, 1, 2, 0};
        bit e_ovf[6] = '{0, 0, 1, 0, 0, 1};
`else
        int e_cnt[6] = '{0, 1, 2, 0, 1, 2};
        bit e_ovf[6] = '{1, 0, 0, 1, 0, 0};
`endif
        prep(2'b00, 7, 0, 0);
        en = 1'b1;
        cyc(5);
        checks++; if (counter_value !== 5) begin errors++; $display("FAIL pchg_start got %0d want 5", counter_value); end
        period = 2;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            checks++; if (counter_value !== e_cnt[k]) begin errors++; $display("FAIL pchg_count[%0d] got %0d want %0d", k, counter_value, e_cnt[k]); end
            checks++; if (overflow !== e_ovf[k]) begin errors++; $display("FAIL pchg_ovf[%0d] got %b want %b", k, overflow, e_ovf[k]); end
        end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_period_zero();
        prep(2'b00, 0, 0, 0);
        en = 1'b1;
        cyc(1);
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL pzero_up_count got %0d want 0", counter_value); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pzero_up_ovf got %b want 1", overflow); end
        mode = 2'b01;
        cyc(1);
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL pzero_down_count got %0d want 0", counter_value); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL pzero_down_ovf got %b want 1", overflow); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL pzero_down_dir got %b want 1", dir); end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_en_hold();
        prep(2'b00, 7, 1, 0);
        en = 1'b1;
        cyc(1);
        checks++; if (tick !== 1'b0 || counter_value !== 0) begin errors++; $display("FAIL hold_first got cnt %0d tick %b want 0/0", counter_value, tick); end
        cyc(1);
        checks++; if (tick !== 1'b1 || counter_value !== 1) begin errors++; $display("FAIL hold_tick got cnt %0d tick %b want 1/1", counter_value, tick); end
        en = 1'b0;
        cyc(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL hold_running got %b want 0", running); end
        cyc(1);
        checks++; if (tick !== 1'b0 || counter_value !== 1) begin errors++; $display("FAIL hold_idle got cnt %0d tick %b want 1/0", counter_value, tick); end
        en = 1'b1;
        cyc(1);
        checks++; if (tick !== 1'b0 || counter_value !== 1 || running !== 1'b1) begin errors++; $display("FAIL hold_resume got cnt %0d tick %b run %b want 1/0/1", counter_value, tick, running); end
        cyc(1);
        checks++; if (tick !== 1'b1 || counter_value !== 2) begin errors++; $display("FAIL hold_next got cnt %0d tick %b want 2/1", counter_value, tick); end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_load_priority();
        prep(2'b00, 7, 0, 0);
        en = 1'b1;
        cyc(2);
        load_value = 5; load = 1'b1;
        cyc(1);
        load = 1'b0;
        checks++; if (counter_value !== 5) begin errors++; $display("FAIL load_count got %0d want 5", counter_value); end
        checks++; if (tick !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL load_pulses got tick %b ovf %b want 0/0", tick, overflow); end
        cyc(1);
        checks++; if (counter_value !== 6) begin errors++; $display("FAIL load_continue got %0d want 6", counter_value); end
        en = 1'b0;
        cyc(1);
    endtask

    task automatic test_async_reset();
        prep(2'b00, 7, 0, 0);
        en = 1'b1;
        cyc(3);
        #3 rst = 1'b0;
        #1;
        checks++; if (counter_value !== 0) begin errors++; $display("FAIL areset_count got %0d want 0", counter_value); end
        checks++; if (tick !== 1'b0 || running !== 1'b0 || flag !== 2'b00) begin errors++; $display("FAIL areset_ctrl got tick %b run %b flag %b want 0/0/00", tick, running, flag); end
        en = 1'b0; mode = 2'b01; period = 3; presc_value = 0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        checks++; if (counter_value !== 0 || dir !== 1'b1) begin errors++; $display("FAIL areset_idle got cnt %0d dir %b want 0/1", counter_value, dir); end
        en = 1'b1;
        cyc(1);
        checks++; if (counter_value !== 3) begin errors++; $display("FAIL areset_down_first got %0d want 3", counter_value); end
        en = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_up();
        test_down();
        test_updown();
        test_oneshot();
        test_flag();
        test_period_change();
        test_period_zero();
        test_en_hold();
        test_load_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Time-base stage of the timer, directly upstream of the PWM/output stage. Prescales `clk` into count ticks and runs a `COUNTER_SIZE`-bit counter in up, down, up-down or one-shot mode against a programmable period. Produces `counter_value` and sticky per-comparator `flag` bits, which the output stage consumes for match detection, interrupts and PWM edges.

## Interface
- `COUNTER_SIZE`, 32, counter, period and load width
- `NUM_COMP`, 2, number of compare channels
- `PRESC_SIZE`, 16, prescaler width

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable
- `presc_value`  in  PRESC_SIZE  tick every `presc_value+1` enabled cycles
- `period`  in  COUNTER_SIZE  counter top value
- `mode`  in  2  00 up, 01 down, 10 up-down, 11 one-shot up
- `load`  in  1  synchronous load strobe
- `load_value`  in  COUNTER_SIZE  value written on `load`
- `match_value`  in  NUM_COMP×COUNTER_SIZE  compare values
- `flag_clr`  in  NUM_COMP  per-channel flag clear, 1-cycle strobe
- `counter_value`  out  COUNTER_SIZE  current count
- `tick`  out  1  registered, 1-cycle pulse when counter advanced this cycle
- `overflow`  out  1  registered, 1-cycle pulse on wrap
- `dir`  out  1  1 = counting down
- `flag`  out  NUM_COMP  sticky match flags
- `running`  out  1  `en` and one-shot not finished

## Operation
- Reset (`rst`=0): all outputs and internal state 0; `dir`=0, except in down mode, where the counter loads `period` on the first tick after release.
- Prescaler: `presc_cnt` increments each cycle with `en`=1. At `presc_cnt == presc_value`, a tick fires and `presc_cnt` returns to 0. `presc_value`=0 gives a tick every cycle. `en`=0 holds `presc_cnt` and counter; no tick.
- Priority per cycle: `load` > tick > hold.
  - `load`: `counter_value`←`load_value`, `presc_cnt`←0, one-shot re-armed; no `tick`/`overflow`. Load works with `en`=0.
- Up: on tick, count+1. At count ≥ `period`, next value is 0 and `overflow` fires.
- Down: on tick, count−1. At 0, next value is `period` and `overflow` fires.
- Up-down: counts up to `period`, `dir`←1, down to 0, `dir`←0.
  - `overflow` fires only on reaching 0 from down.
  - The top and bottom values are each held for one tick.
- One-shot: counts up; on reaching `period`, stops, `overflow` fires once and `running`←0. Further ticks ignored until `load`.
- `period`=0: count stays 0; `overflow` fires every tick (every mode).
- Mode change mid-count: takes effect on the next tick from the current value; `dir` is forced to match the new mode (up/one-shot 0, down 1).
- Flags: `flag[i]` sets when a tick or load produces next count == `match_value[i]`. `flag_clr[i]` clears it. Set wins over a simultaneous clear.

## Timing
- All outputs are registered.
- `counter_value`, `tick`, `overflow` and `flag` update on the same edge.
- `en` rising: first tick after `presc_value+1` cycles.
- `running` follows `en` with one-cycle latency.
- Asynchronous reset mid-count clears everything immediately; the count restarts from 0 (or `period` for down) on the first tick after release.

## Configuration
- `TIMER_SHADOW_EN` defined:
  - `period` and `match_value` are double-buffered.
  - The active copies update on an `overflow` edge, on `load`, and on every cycle with `en`=0.
  - Writes mid-period do not affect the current period.
- Undefined: `period` and `match_value` are used directly each cycle; a write below the current count in up mode causes wrap on the next tick.

## Test plan
- Up, `period`=4, `presc_value`=0, `en`=1 → count 0,1,2,3,4,0; `overflow` on the 4→0 edge, period 5 cycles.
- Down, `period`=3, `presc_value`=2 → count changes every 3 cycles: 3,2,1,0,3; `overflow` on 0→3; `tick` pulses 1 cycle.
- Up-down, `period`=2 → 0,1,2,1,0,1; `dir` 1 while descending; `overflow` only at 1→0.
- One-shot, `period`=5 → stops at 5, `running`=0, single `overflow`. Then `load` with `load_value`=0 → restarts from 0.
- `match_value[0]`=3, up, `period`=7 → `flag[0]` sets on the edge count becomes 3. `flag_clr[0]` asserted the same cycle as a second match → flag stays 1.
- With `TIMER_SHADOW_EN`: `period` changed 7→2 at count 5 → count continues to 7, wraps; next period is 0..2. Without the macro: next tick wraps to 0 with `overflow`.
